sdram_read_arbiter: RTL

Shares the single HPS FPGA-to-SDRAM read port (f2h_sdram0, 64-bit Avalon-MM, read-only) between `NUM_MASTERS` fabric read masters, e.g. scanout and vertex/texture fetch. It grants one whole burst at a time, round-robin, and forwards that burst's address phase and returned data beats. One burst is outstanding at most. It sits between the GPU read engines and the `hps_0_f2h_sdram0_data_*` conduit of the soc_system instance.

---
 rtl/gpu_mem_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 47 ++++
 rtl/sdram_read_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/gpu_mem_pkg.sv
// Shared GPU memory-side types and SDRAM port constants.
// Used by the FPGA-to-SDRAM read arbiter and its grant selector.
package gpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2
  } arb_state_t;

  localparam int SDRAM_ADDR_W  = 29;
  localparam int SDRAM_BURST_W = 8;
  localparam int SDRAM_DATA_W  = 64;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational next-grant selector: round-robin from last_grant+1, or fixed
// priority (index 0 highest) when SDRAM_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     gnt_oh,
  output logic [IDX_W-1:0] gnt_idx
);

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  // Walk from the lowest priority up so the lowest set index wins.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_oh    = '0;
        gnt_oh[i] = 1'b1;
        gnt_idx   = IDX_W'(i);
      end
    end
  end
`else
  // Offsets walked farthest-first so offset 1 (last_grant+1) overrides all.
  always_comb begin
    logic [31:0] j;
    gnt_oh  = '0;
    gnt_idx = '0;
    j       = '0;
    for (int k = N; k >= 1; k--) begin
      j = (32'(last_grant) + 32'(k)) % 32'(N);
      if (req[j]) begin
        gnt_oh    = '0;
        gnt_oh[j] = 1'b1;
        gnt_idx   = j[IDX_W-1:0];
      end
    end
  end
`endif

endmodule

// File: rtl/sdram_read_arbiter.sv
// Shares the HPS f2h_sdram0 read port between NUM_MASTERS fabric readers, one
// whole burst at a time. Define SDRAM_ARB_FIXED_PRIO_EN for fixed priority.
module sdram_read_arbiter
  import gpu_mem_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = SDRAM_ADDR_W,
  parameter int BURST_W     = SDRAM_BURST_W,
  parameter int DATA_W      = SDRAM_DATA_W
) (
  input  logic                           clk_clk,
  input  logic                           reset_reset,
  input  logic [NUM_MASTERS-1:0]         m_read,
  input  logic [NUM_MASTERS*ADDR_W-1:0]  m_address,
  input  logic [NUM_MASTERS*BURST_W-1:0] m_burstcount,
  output logic [NUM_MASTERS-1:0]         m_waitrequest,
  output logic [DATA_W-1:0]              m_readdata,
  output logic [NUM_MASTERS-1:0]         m_readdatavalid,
  output logic                           sdram_read,
  output logic [ADDR_W-1:0]              sdram_address,
  output logic [BURST_W-1:0]             sdram_burstcount,
  input  logic                           sdram_waitrequest,
  input  logic [DATA_W-1:0]              sdram_readdata,
  input  logic                           sdram_readdatavalid,
  output logic                           busy
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0][ADDR_W-1:0]  addr_a;
  logic [NUM_MASTERS-1:0][BURST_W-1:0] bc_a;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign addr_a[i] = m_address[i*ADDR_W +: ADDR_W];
    assign bc_a[i]   = m_burstcount[i*BURST_W +: BURST_W];
  end

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [BURST_W-1:0] beats_left_q, beats_left_d;

  logic [NUM_MASTERS-1:0] arb_oh;
  logic [IDX_W-1:0]       arb_idx;
  logic [BURST_W-1:0]     sel_bc;

  rr_arbiter #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_arb (
    .req        (m_read),
    .last_grant (last_grant_q),
    .gnt_oh     (arb_oh),
    .gnt_idx    (arb_idx)
  );

  // A zero burstcount is illegal on Avalon; issue and count it as one beat.
  assign sel_bc = (bc_a[grant_q] == '0) ? BURST_W'(1) : bc_a[grant_q];

  assign sdram_address    = addr_a[grant_q];
  assign sdram_burstcount = sel_bc;
  assign m_readdata       = sdram_readdata;
  assign busy             = (state_q != IDLE);

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_grant_d    = last_grant_q;
    beats_left_d    = beats_left_q;
    sdram_read      = 1'b0;
    m_waitrequest   = '1;
    m_readdatavalid = '0;
    case (state_q)
      IDLE: begin
        if (|arb_oh) begin
          grant_d = arb_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        sdram_read             = m_read[grant_q];
        m_waitrequest[grant_q] = sdram_waitrequest;
        // Master withdrew before acceptance: abandon without issuing.
        if (!m_read[grant_q]) begin
          state_d = IDLE;
        end else if (!sdram_waitrequest) begin
          beats_left_d = sel_bc;
          last_grant_d = grant_q;
          state_d      = DATA;
        end
      end
      DATA: begin
        if (sdram_readdatavalid) begin
          m_readdatavalid[grant_q] = 1'b1;
          beats_left_d             = beats_left_q - BURST_W'(1);
          if (beats_left_q == BURST_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_MASTERS - 1);
      beats_left_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beats_left_q <= beats_left_d;
    end
  end

endmodule
